rc5_cipher_sched: RTL and testbench

- Scheduler/arbiter in front of the RC5 core: sequences the key-expansion unit once per key load, then shares the encryption datapath between two block requesters (round-robin).
- Owns start/done handshakes to the key-schedule and encrypt engines and returns ciphertext tagged with requester id.
- Watchdog flags a hung engine.

---
 rtl/rc5_cipher_sched_if.sv | 22 ++
 rtl/rc5_cipher_sched.sv | 71 +++++++
 tb/tb_rc5_cipher_sched.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc5_cipher_sched_if.sv
// rc5_cipher_sched_if: requester, engine and result signals of the RC5 scheduler
interface rc5_cipher_sched_if #(parameter int W = 32);
  logic key_load, key_valid, error;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
  logic ks_start, ks_done, enc_start, enc_done;
  logic [W-1:0] enc_A, enc_B, enc_A_res, enc_B_res;
  logic res_valid, res_id, res_ready;
  logic [W-1:0] res_A, res_B;
  modport slave (
    input key_load, req0_valid, req0_A, req0_B, req1_valid, req1_A, req1_B,
          ks_done, enc_done, enc_A_res, enc_B_res, res_ready,
    output key_valid, error, req0_ready, req1_ready, ks_start, enc_start,
           enc_A, enc_B, res_valid, res_id, res_A, res_B
  );
  modport master (
    output key_load, req0_valid, req0_A, req0_B, req1_valid, req1_A, req1_B,
           ks_done, enc_done, enc_A_res, enc_B_res, res_ready,
    input key_valid, error, req0_ready, req1_ready, ks_start, enc_start,
          enc_A, enc_B, res_valid, res_id, res_A, res_B
  );
endinterface

// File: rtl/rc5_cipher_sched.sv
// rc5_cipher_sched: sequences key expansion and round-robin shares the RC5 encrypt engine
module rc5_cipher_sched #(
  parameter int W = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_LEN = 11
) (
  input logic clk,
  input logic rst,
  rc5_cipher_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, KS, GRANT, ENC, HOLD, ERR} state_t;
  state_t state, nxt;
  logic last_grant, key_pend, g1, any, wd_exp;
  logic [TO_LEN-1:0] wd;
  // g1 picks requester 1 when it alone is valid or when both are and 0 went last
  assign any = bus.req0_valid | bus.req1_valid;
  assign g1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  assign wd_exp = wd == TO_LEN'(TIMEOUT - 1);
  assign bus.req0_ready = (state == GRANT) & any & ~g1;
  assign bus.req1_ready = (state == GRANT) & g1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (key_pend | bus.key_load) ? KS : (bus.key_valid & any) ? GRANT : IDLE;
      KS:      nxt = bus.ks_done ? IDLE : wd_exp ? ERR : KS;
      GRANT:   nxt = any ? ENC : IDLE;
      ENC:     nxt = bus.enc_done ? HOLD : wd_exp ? ERR : ENC;
      HOLD:    nxt = bus.res_ready ? IDLE : HOLD;
      default: nxt = ERR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b1;
      key_pend <= 1'b0;
      wd <= '0;
      bus.ks_start <= 1'b0;
      bus.enc_start <= 1'b0;
      bus.key_valid <= 1'b0;
      bus.error <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_id <= 1'b0;
      bus.enc_A <= {W{1'b0}};
      bus.enc_B <= {W{1'b0}};
      bus.res_A <= {W{1'b0}};
      bus.res_B <= {W{1'b0}};
    end else begin
      key_pend <= (state != IDLE) & (state != ERR) & (key_pend | bus.key_load);
      wd <= (state == KS || state == ENC) ? wd + 1'b1 : '0;
      bus.ks_start <= (state == IDLE) & (nxt == KS);
      bus.enc_start <= (state == GRANT) & (nxt == ENC);
      bus.key_valid <= (nxt == ERR || nxt == KS) ? 1'b0 : (state == KS && bus.ks_done) ? 1'b1 : bus.key_valid;
      bus.error <= bus.error | (nxt == ERR);
      bus.res_valid <= (state == ENC && bus.enc_done) ? 1'b1 : (state == HOLD && bus.res_ready) ? 1'b0 : bus.res_valid;
      if (state == GRANT && any) begin
        last_grant <= g1;
        bus.res_id <= g1;
        bus.enc_A <= g1 ? bus.req1_A : bus.req0_A;
        bus.enc_B <= g1 ? bus.req1_B : bus.req0_B;
      end
      if (state == ENC && bus.enc_done) begin
        bus.res_A <= bus.enc_A_res;
        bus.res_B <= bus.enc_B_res;
      end
    end
  end
endmodule

// File: tb/tb_rc5_cipher_sched.sv
// tb_rc5_cipher_sched: directed scenarios for the RC5 scheduler, sampled and driven on the falling edge
module tb_rc5_cipher_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  rc5_cipher_sched_if #(.W(32)) bus();
  rc5_cipher_sched #(.W(32), .TIMEOUT(1024), .TO_LEN(11)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({bus.ks_start, bus.enc_start, bus.key_valid, bus.error, bus.res_valid, bus.res_id, bus.req0_ready, bus.req1_ready} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000000", {bus.ks_start, bus.enc_start, bus.key_valid, bus.error, bus.res_valid, bus.res_id, bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.enc_A, bus.enc_B, bus.res_A, bus.res_B} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {bus.enc_A, bus.enc_B, bus.res_A, bus.res_B});
    end
    rst = 1'b1;
  endtask
  task automatic test_key_load();
    int pulses = 0;
    bus.key_load = 1'b1;
    step();
    bus.key_load = 1'b0;
    checks++;
    if (bus.ks_start !== 1'b1 || bus.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL ks_start_first got ks_start=%b key_valid=%b exp 1 0", bus.ks_start, bus.key_valid);
    end
    for (int i = 0; i < 40; i++) begin
      pulses += int'(bus.ks_start);
      step();
    end
    checks++;
    if (pulses != 1 || bus.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL ks_pulses got pulses=%0d key_valid=%b exp 1 0", pulses, bus.key_valid);
    end
    bus.ks_done = 1'b1;
    step();
    bus.ks_done = 1'b0;
    checks++;
    if (bus.key_valid !== 1'b1 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL key_valid_set got key_valid=%b error=%b exp 1 0", bus.key_valid, bus.error);
    end
  endtask
  task automatic serve(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ra, input logic [31:0] rb, input int lat, input bit drop, input bit kl);
    int n = 0;
    bit bad = 1'b0;
    while (!(bus.req0_ready | bus.req1_ready) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant got ready=%b exp=%b", {bus.req1_ready, bus.req0_ready}, id ? 2'b10 : 2'b01);
    end
    step();
    if (drop) begin
      if (id) bus.req1_valid = 1'b0;
      else bus.req0_valid = 1'b0;
    end
    checks++;
    if (bus.enc_start !== 1'b1 || bus.enc_A !== a || bus.enc_B !== b || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL enc_start got start=%b A=%h B=%h exp 1 %h %h", bus.enc_start, bus.enc_A, bus.enc_B, a, b);
    end
    for (int i = 1; i < lat; i++) begin
      if (i == 2) bus.key_load = kl;
      if (i == 3) bus.key_load = 1'b0;
      step();
      bad |= bus.enc_start | bus.req0_ready | bus.req1_ready | bus.res_valid | bus.ks_start | (bus.enc_A !== a) | (bus.enc_B !== b);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL enc_wait got operands unstable or stray strobe exp stable A=%h B=%h", a, b);
    end
    bus.enc_done = 1'b1;
    bus.enc_A_res = ra;
    bus.enc_B_res = rb;
    step();
    bus.enc_done = 1'b0;
    bus.enc_A_res = 32'hdeadbeef;
    bus.enc_B_res = 32'hdeadbeef;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== id || bus.res_A !== ra || bus.res_B !== rb) begin
      errors++;
      $display("FAIL result got v=%b id=%b A=%h B=%h exp 1 %b %h %h", bus.res_valid, bus.res_id, bus.res_A, bus.res_B, id, ra, rb);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      bad |= bus.req0_ready | bus.req1_ready | bus.enc_start | !bus.res_valid | (bus.res_A !== ra) | (bus.res_B !== rb) | (bus.res_id !== id);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold got result dropped or grant while holding exp stable %h %h", ra, rb);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL res_clear got res_valid=%b exp 0", bus.res_valid);
    end
  endtask
  task automatic test_single();
    bus.req0_A = 32'd10;
    bus.req0_B = 32'd20;
    bus.req0_valid = 1'b1;
    serve(1'b0, 32'd10, 32'd20, 32'h11111111, 32'h22222222, 30, 1'b1, 1'b0);
  endtask
  task automatic test_back_to_back();
    test_reset();
    test_key_load();
    bus.req0_A = 32'h1;
    bus.req0_B = 32'h2;
    bus.req1_A = 32'h3;
    bus.req1_B = 32'h4;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    serve(1'b0, 32'h1, 32'h2, 32'ha0a0a0a0, 32'hb0b0b0b0, 5, 1'b0, 1'b0);
    serve(1'b1, 32'h3, 32'h4, 32'ha1a1a1a1, 32'hb1b1b1b1, 6, 1'b0, 1'b0);
    serve(1'b0, 32'h1, 32'h2, 32'ha2a2a2a2, 32'hb2b2b2b2, 4, 1'b0, 1'b0);
    serve(1'b1, 32'h3, 32'h4, 32'ha3a3a3a3, 32'hb3b3b3b3, 7, 1'b1, 1'b0);
  endtask
  task automatic test_key_during_enc();
    bit bad = 1'b0;
    bus.req0_A = 32'h5;
    bus.req0_B = 32'h6;
    bus.req1_A = 32'h7;
    bus.req1_B = 32'h8;
    bus.req1_valid = 1'b1;
    serve(1'b0, 32'h5, 32'h6, 32'hc0c0c0c0, 32'hd0d0d0d0, 8, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.ks_start !== 1'b1 || bus.key_valid !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL pend_ks got ks_start=%b key_valid=%b ready1=%b exp 1 0 0", bus.ks_start, bus.key_valid, bus.req1_ready);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      bad |= bus.req0_ready | bus.req1_ready | bus.key_valid | bus.ks_start;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ks_blocks got grant or key_valid during KS exp none");
    end
    bus.ks_done = 1'b1;
    step();
    bus.ks_done = 1'b0;
    checks++;
    if (bus.key_valid !== 1'b1) begin
      errors++;
      $display("FAIL rekey_valid got key_valid=%b exp 1", bus.key_valid);
    end
    serve(1'b1, 32'h7, 32'h8, 32'hc1c1c1c1, 32'hd1d1d1d1, 5, 1'b1, 1'b0);
  endtask
  task automatic test_timeout();
    int n = 0;
    bit bad = 1'b0;
    bus.req0_A = 32'h9;
    bus.req0_B = 32'h9;
    bus.req0_valid = 1'b1;
    while (!bus.req0_ready && n < 20) begin
      step();
      n++;
    end
    step();
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.enc_start !== 1'b1) begin
      errors++;
      $display("FAIL to_start got enc_start=%b exp 1", bus.enc_start);
    end
    for (int i = 0; i < 1023; i++) begin
      step();
      bad |= bus.error;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL to_early got error before 1024 cycles exp 0");
    end
    step();
    checks++;
    if (bus.error !== 1'b1 || bus.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_fire got error=%b key_valid=%b exp 1 0", bus.error, bus.key_valid);
    end
    bad = 1'b0;
    bus.enc_done = 1'b1;
    bus.ks_done = 1'b1;
    bus.key_load = 1'b1;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      bad |= !bus.error | bus.key_valid | bus.ks_start | bus.enc_start | bus.req0_ready | bus.req1_ready | bus.res_valid;
    end
    bus.enc_done = 1'b0;
    bus.ks_done = 1'b0;
    bus.key_load = 1'b0;
    bus.req0_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL err_sticky got ERR left or strobe raised exp error=1 quiet");
    end
    test_reset();
  endtask
  task automatic test_reset_mid_enc();
    int n = 0;
    bit bad = 1'b0;
    test_key_load();
    bus.req0_A = 32'h77;
    bus.req0_B = 32'h88;
    bus.req0_valid = 1'b1;
    while (!bus.req0_ready && n < 20) begin
      step();
      n++;
    end
    step();
    bus.req0_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.enc_done = 1'b1;
    bus.enc_A_res = 32'h12345678;
    step();
    bus.enc_done = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.key_valid !== 1'b0 || bus.res_A !== 32'h0) begin
      errors++;
      $display("FAIL stray_done got res_valid=%b key_valid=%b res_A=%h exp 0 0 0", bus.res_valid, bus.key_valid, bus.res_A);
    end
    bus.req0_valid = 1'b1;
    bus.ks_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      bad |= bus.req0_ready | bus.req1_ready | bus.enc_start | bus.ks_start | bus.key_valid | bus.res_valid;
    end
    bus.req0_valid = 1'b0;
    bus.ks_done = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_key_idle got activity without key exp none");
    end
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
  initial begin
    {bus.key_load, bus.req0_valid, bus.req1_valid, bus.ks_done, bus.enc_done, bus.res_ready} = '0;
    {bus.req0_A, bus.req0_B, bus.req1_A, bus.req1_B, bus.enc_A_res, bus.enc_B_res} = '0;
    test_reset();
    test_key_load();
    test_single();
    test_back_to_back();
    test_key_during_enc();
    test_timeout();
    test_reset_mid_enc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
